// File: rtl/dual_port_ram.sv
// Two-port synchronous RAM: independent write and read channel per port, one clock.
// Only the read-data registers are reset; the storage array keeps its contents across reset.
module dual_port_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_1,
    input  logic                  we_2,
    input  logic [DATA_WIDTH-1:0] data_in_1,
    input  logic [DATA_WIDTH-1:0] data_in_2,
    input  logic [ADDR_WIDTH-1:0] read_addr_1,
    input  logic [ADDR_WIDTH-1:0] read_addr_2,
    input  logic [ADDR_WIDTH-1:0] write_addr_1,
    input  logic [ADDR_WIDTH-1:0] write_addr_2,
    output logic [DATA_WIDTH-1:0] data_out_1,
    output logic [DATA_WIDTH-1:0] data_out_2
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [Depth];

    logic [DATA_WIDTH-1:0] rd_1_d, rd_1_q;
    logic [DATA_WIDTH-1:0] rd_2_d, rd_2_q;

    // Port 2 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (we_1) begin
                mem[write_addr_1] <= data_in_1;
            end
            if (we_2) begin
                mem[write_addr_2] <= data_in_2;
            end
        end
    end

    always_comb begin
        rd_1_d = mem[read_addr_1];
        rd_2_d = mem[read_addr_2];
    end

    // Non-blocking update gives old-data behaviour on read-during-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_1_q <= '0;
            rd_2_q <= '0;
        end else begin
            rd_1_q <= rd_1_d;
            rd_2_q <= rd_2_d;
        end
    end

    assign data_out_1 = rd_1_q;
    assign data_out_2 = rd_2_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// Self-checking bench for dual_port_ram: directed vector table, hand-written reset
// sequences and a randomized phase checked against an array-based memory model.
module tb_dual_port_ram;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 15;
    localparam int unsigned NWORDS = 2 ** AW;

    logic          clk;
    logic          rst_n;
    logic          we_1, we_2;
    logic [DW-1:0] data_in_1, data_in_2;
    logic [AW-1:0] read_addr_1, read_addr_2;
    logic [AW-1:0] write_addr_1, write_addr_2;
    logic [DW-1:0] data_out_1, data_out_2;

    dual_port_ram #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .we_1        (we_1),
        .we_2        (we_2),
        .data_in_1   (data_in_1),
        .data_in_2   (data_in_2),
        .read_addr_1 (read_addr_1),
        .read_addr_2 (read_addr_2),
        .write_addr_1(write_addr_1),
        .write_addr_2(write_addr_2),
        .data_out_1  (data_out_1),
        .data_out_2  (data_out_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we1;
        logic          we2;
        logic [AW-1:0] wa1;
        logic [AW-1:0] wa2;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        bit            c1;
        bit            c2;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } vec_t;

    vec_t vecs[$];

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: plain word array plus a "has been written" flag per word.
    logic [DW-1:0] model_mem [NWORDS];
    bit            model_vld [NWORDS];

    logic [DW-1:0] m_exp1, m_exp2;
    bit            m_k1, m_k2;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic check_not(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] bad);
        n_total++;
        if (act !== bad) n_pass++;
        else $display("FAIL %s: got %h, required anything but %h", name, act, bad);
    endtask

    task automatic drive(input vec_t v);
        we_1         = v.we1;
        we_2         = v.we2;
        write_addr_1 = v.wa1;
        write_addr_2 = v.wa2;
        data_in_1    = v.d1;
        data_in_2    = v.d2;
        read_addr_1  = v.ra1;
        read_addr_2  = v.ra2;
    endtask

    // One clock: predict outputs from the pre-edge model, then commit this edge's writes.
    task automatic tick();
        bit rst_at_edge;
        m_k1   = model_vld[read_addr_1];
        m_exp1 = model_mem[read_addr_1];
        m_k2   = model_vld[read_addr_2];
        m_exp2 = model_mem[read_addr_2];
        @(posedge clk);
        #1;
        rst_at_edge = !rst_n;
        if (rst_at_edge) begin
            m_k1 = 1'b1; m_exp1 = '0;
            m_k2 = 1'b1; m_exp2 = '0;
        end else begin
            if (we_2) begin
                model_mem[write_addr_2] = data_in_2;
                model_vld[write_addr_2] = 1'b1;
            end
            if (we_1 && !(we_2 && write_addr_1 == write_addr_2)) begin
                model_mem[write_addr_1] = data_in_1;
                model_vld[write_addr_1] = 1'b1;
            end
        end
    endtask

    function automatic void add(input logic we1, input logic [AW-1:0] wa1, input logic [DW-1:0] d1,
                                input logic we2, input logic [AW-1:0] wa2, input logic [DW-1:0] d2,
                                input logic [AW-1:0] ra1, input bit c1, input logic [DW-1:0] e1,
                                input logic [AW-1:0] ra2, input bit c2, input logic [DW-1:0] e2);
        vec_t v;
        v.we1 = we1; v.wa1 = wa1; v.d1 = d1;
        v.we2 = we2; v.wa2 = wa2; v.d2 = d2;
        v.ra1 = ra1; v.c1 = c1; v.e1 = e1;
        v.ra2 = ra2; v.c2 = c2; v.e2 = e2;
        vecs.push_back(v);
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) a = a + 15'h7FF0;
        return a;
    endfunction

    initial begin
        vec_t v;
        for (int i = 0; i < int'(NWORDS); i++) model_vld[i] = 1'b0;

        // Reset held with writes requested: outputs 0, writes suppressed.
        rst_n = 1'b0;
        v = '{we1: 1'b1, we2: 1'b1, wa1: 15'h0200, wa2: 15'h0201, d1: 8'hFF, d2: 8'hFF,
              ra1: 15'h0200, ra2: 15'h0201, c1: 1'b0, c2: 1'b0, e1: 8'h00, e2: 8'h00};
        drive(v);
        #1;
        check("rst_initial_1", data_out_1, 8'h00);
        check("rst_initial_2", data_out_2, 8'h00);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_hold_1", data_out_1, 8'h00);
            check("rst_hold_2", data_out_2, 8'h00);
        end
        rst_n = 1'b1;
        we_1  = 1'b0;
        we_2  = 1'b0;
        tick();
        check_not("rst_write_lost_1", data_out_1, 8'hFF);
        check_not("rst_write_lost_2", data_out_2, 8'hFF);

        // Directed vector table.
        for (int i = 1; i <= 8; i++)
            add(1'b1, AW'(i), DW'(i), 1'b1, AW'(15'h0100 + i), DW'(8'h80 + i),
                15'h0000, 1'b0, 8'h00, 15'h0000, 1'b0, 8'h00);
        for (int i = 1; i <= 8; i++)
            add(1'b0, 15'h0000, 8'h00, 1'b0, 15'h0000, 8'h00,
                AW'(i), 1'b1, DW'(i), AW'(15'h0100 + i), 1'b1, DW'(8'h80 + i));
        add(1'b1, 15'h0010, 8'h55, 1'b0, 15'h0000, 8'h00, 15'h0001, 1'b1, 8'h01,
            15'h0101, 1'b1, 8'h81);
        add(1'b1, 15'h0010, 8'hAA, 1'b0, 15'h0000, 8'h00, 15'h0010, 1'b1, 8'h55,
            15'h0010, 1'b1, 8'h55);
        add(1'b0, 15'h0000, 8'h00, 1'b0, 15'h0000, 8'h00, 15'h0010, 1'b1, 8'hAA,
            15'h0010, 1'b1, 8'hAA);
        add(1'b0, 15'h0000, 8'h00, 1'b1, 15'h0010, 8'h77, 15'h0010, 1'b1, 8'hAA,
            15'h0001, 1'b1, 8'h01);
        add(1'b0, 15'h0000, 8'h00, 1'b0, 15'h0000, 8'h00, 15'h0010, 1'b1, 8'h77,
            15'h0002, 1'b1, 8'h02);
        add(1'b1, 15'h7FFF, 8'h3C, 1'b0, 15'h0000, 8'h00, 15'h0003, 1'b1, 8'h03,
            15'h0004, 1'b1, 8'h04);
        add(1'b0, 15'h0000, 8'h00, 1'b0, 15'h0000, 8'h00, 15'h0005, 1'b1, 8'h05,
            15'h7FFF, 1'b1, 8'h3C);
        add(1'b1, 15'h0000, 8'h11, 1'b1, 15'h0000, 8'h22, 15'h0006, 1'b1, 8'h06,
            15'h0007, 1'b1, 8'h07);
        add(1'b0, 15'h0000, 8'h00, 1'b1, 15'h4000, 8'h5A, 15'h0000, 1'b1, 8'h22,
            15'h0000, 1'b1, 8'h22);
        add(1'b0, 15'h0001, 8'hEE, 1'b0, 15'h0002, 8'hDD, 15'h0000, 1'b1, 8'h22,
            15'h4000, 1'b1, 8'h5A);
        add(1'b0, 15'h0000, 8'h00, 1'b0, 15'h0000, 8'h00, 15'h0001, 1'b1, 8'h01,
            15'h0002, 1'b1, 8'h02);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            tick();
            if (vecs[i].c1) check($sformatf("vec%0d_p1", i), data_out_1, vecs[i].e1);
            if (vecs[i].c2) check($sformatf("vec%0d_p2", i), data_out_2, vecs[i].e2);
        end

        // Write burst interrupted by an asynchronous reset pulse.
        for (int i = 0; i < 3; i++) begin
            v = '{we1: 1'b1, we2: 1'b0, wa1: AW'(15'h0300 + i), wa2: 15'h0000,
                  d1: DW'(8'hA0 + i), d2: 8'h00, ra1: 15'h0300, ra2: 15'h0010,
                  c1: 1'b0, c2: 1'b0, e1: 8'h00, e2: 8'h00};
            drive(v);
            tick();
        end
        check("burst_pre_rst_1", data_out_1, 8'hA0);
        check("burst_pre_rst_2", data_out_2, 8'h77);
        write_addr_1 = 15'h0303;
        data_in_1    = 8'hA3;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_1", data_out_1, 8'h00);
        check("rst_async_2", data_out_2, 8'h00);
        tick();
        check("rst_edge_1", data_out_1, 8'h00);
        rst_n = 1'b1;
        we_1  = 1'b0;
        read_addr_1 = 15'h0300;
        read_addr_2 = 15'h0301;
        tick();
        check("post_rst_300", data_out_1, 8'hA0);
        check("post_rst_301", data_out_2, 8'hA1);
        read_addr_1 = 15'h0302;
        read_addr_2 = 15'h0303;
        tick();
        check("post_rst_302", data_out_1, 8'hA2);
        check_not("post_rst_303_lost", data_out_2, 8'hA3);

        // Randomized traffic on a small address window to provoke collisions.
        for (int i = 0; i < 600; i++) begin
            we_1         = 1'($urandom_range(0, 1));
            we_2         = 1'($urandom_range(0, 1));
            write_addr_1 = rand_addr();
            write_addr_2 = ($urandom_range(0, 3) == 0) ? write_addr_1 : rand_addr();
            read_addr_1  = ($urandom_range(0, 3) == 0) ? write_addr_2 : rand_addr();
            read_addr_2  = ($urandom_range(0, 3) == 0) ? write_addr_1 : rand_addr();
            data_in_1    = DW'($urandom_range(0, 255));
            data_in_2    = DW'($urandom_range(0, 255));
            tick();
            if (m_k1) check("rand_p1", data_out_1, m_exp1);
            if (m_k2) check("rand_p2", data_out_2, m_exp2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
